spi_xfer_arbiter: RTL
=====================

// Module: spi_xfer_arbiter
// PURPOSE
//  Shares one SPI master (CS/SCK timing + shift datapath) between NREQ requesters.
//  Round-robin arbitration, latching of each winner's per-transfer config (cpol/cpha/mode/widths/data),
//  sequencing of the master's enable, and return of read data plus a per-requester completion pulse.
//  Sits between the application-side command sources and the SPI master.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  DW          32    data width; SPI widths are 6 bit, legal range 1..32
//  GAP_CYCLES  2     clk cycles spi_en is held low between transfers (>=1)
//  TIMEOUT     4096  RUN-state watchdog limit in clk cycles (only with SPI_ARB_TIMEOUT_EN)
// PORTS
//  clk            in   1          system clock
//  rst            in   1          synchronous reset, active-high
//  req_valid      in   NREQ       request pending, one bit per requester
//  req_ready      out  NREQ       one-hot accept; transfer happens on valid&ready
//  req_cpol       in   NREQ       per-requester clock idle level
//  req_cpha       in   NREQ       per-requester clock phase
//  req_mode       in   2*NREQ     per-requester w_r_mode (00 rd, 01 wr, 10 wr-then-rd)
//  req_wr_width   in   6*NREQ     per-requester write width
//  req_rd_width   in   6*NREQ     per-requester read width
//  req_wr_data    in   DW*NREQ    per-requester write data
//  rsp_valid      out  NREQ       one-hot 1-cycle completion pulse
//  rsp_rd_data    out  DW         read data, valid with rsp_valid
//  rsp_err        out  1          error flag, valid with rsp_valid
//  busy           out  1          high in every state except IDLE
//  grant_id       out  $clog2(NREQ)  index of current/last granted requester
//  spi_en         out  1          enable to SPI master; held high for whole transfer
//  spi_cpol/spi_cpha   out 1 each  latched config to master
//  spi_w_r_mode   out  2;  spi_wr_width, spi_rd_width  out 6 each;  spi_wr_data  out DW
//  spi_done       in   1          1-cycle pulse from master: transfer complete, CS back high
//  spi_rd_data    in   DW         master read data, valid with spi_done
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, rr pointer so requester 0 has highest priority first.
//  States IDLE -> RUN -> GAP -> IDLE; IDLE -> GAP directly on config error.
//  IDLE: winner = first req_valid bit at or after (last_grant+1) mod NREQ; req_ready[winner]=1
//   combinationally same cycle; config latched into spi_* regs; grant_id/pointer updated.
//   req_ready is 0 outside IDLE and for non-winners. Requester holds config stable while valid.
//  Config error (mode==11, or active width 0 or >32: mode00 rd, mode01 wr, mode10 either/sum>32... 
//   precisely: mode10 requires wr,rd each 1..32): accepted, no spi_en, next cycle
//   rsp_valid[winner]=1, rsp_err=1, rsp_rd_data=0, -> GAP.
//  RUN: spi_en=1 from the cycle after acceptance; on spi_done: rsp_rd_data<=spi_rd_data,
//   rsp_err<=0, rsp_valid[grant] pulses next cycle, spi_en drops same edge, -> GAP.
//  GAP: spi_en=0 for exactly GAP_CYCLES cycles (master counters reset), then IDLE.
//  spi_done outside RUN ignored. req_valid dropping before ready: no grant, no side effects.
//  rst mid-transfer: spi_en low next edge, no rsp_valid for the aborted transfer.
//  Accept-to-spi_en latency 1 cycle; back-to-back grants spaced >= GAP_CYCLES+2 cycles.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined: counter runs in RUN; after TIMEOUT cycles without spi_done,
//   spi_en drops, rsp_valid[grant]=1 with rsp_err=1, rsp_rd_data=0, -> GAP. spi_done on the
//   expiry cycle wins (normal completion). Undefined: no counter, RUN waits indefinitely;
//   rsp_err only signals config errors.
// TESTING
//  Single req0 mode01 wr=8 data 0xA5 -> ready0 same cycle, spi_en next cycle, spi_* = cfg; done -> rsp_valid0, err 0.
//  req0..3 all valid, held -> grants 0,1,2,3,0 in order; spacing >= GAP_CYCLES+2 cycles.
//  req2 mode10 wr=8 rd=16; spi_done with spi_rd_data=0x0000BEEF -> rsp_valid2, rsp_rd_data=0x0000BEEF.
//  req1 mode00 rd=0, then mode11 -> each: rsp_valid1 + rsp_err=1 next cycle, spi_en never high.
//  rst asserted 5 cycles into RUN -> spi_en 0, busy 0, no rsp_valid; next grant starts at req0.
//  SPI_ARB_TIMEOUT_EN, TIMEOUT=16, no spi_done -> spi_en low after 16 RUN cycles, rsp_err=1.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI master between NREQ
// requesters. Latches the winner's transfer config, sequences spi_en
// (RUN, then a GAP_CYCLES low gap) and returns read data with a
// one-hot completion pulse.
// Ports: clk, rst (sync, active-high); req_* per-requester handshake and
// packed config; rsp_valid/rsp_rd_data/rsp_err completion; busy, grant_id
// status; spi_* config/enable to the master; spi_done/spi_rd_data back.
// Optional: define SPI_ARB_TIMEOUT_EN to add a RUN-state watchdog that
// ends a transfer with rsp_err after TIMEOUT cycles without spi_done.
module spi_xfer_arbiter #(
   parameter int NREQ       = 4,
   parameter int DW         = 32,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_cpol,
   input  logic [NREQ-1:0]       req_cpha,
   input  logic [2*NREQ-1:0]     req_mode,
   input  logic [6*NREQ-1:0]     req_wr_width,
   input  logic [6*NREQ-1:0]     req_rd_width,
   input  logic [DW*NREQ-1:0]    req_wr_data,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [DW-1:0]         rsp_rd_data,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                  spi_en,
   output logic                  spi_cpol,
   output logic                  spi_cpha,
   output logic [1:0]            spi_w_r_mode,
   output logic [5:0]            spi_wr_width,
   output logic [5:0]            spi_rd_width,
   output logic [DW-1:0]         spi_wr_data,
   input  logic                  spi_done,
   input  logic [DW-1:0]         spi_rd_data
);

   localparam int IW = $clog2(NREQ);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
      $error("spi_xfer_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   last;
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic            found;
   logic            accept;
   logic            cfg_err;
   logic            done_hit;
   logic            to_hit;
   logic [GW-1:0]   gap_cnt;
   logic [1:0]      w_mode;
   logic [5:0]      w_wr;
   logic [5:0]      w_rd;
   logic [NREQ-1:0] win_oh;
   logic [NREQ-1:0] grant_oh;
   int              widx;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;
`endif

   function automatic logic w_ok(input logic [5:0] w);
      return (w != 6'd0) && (w <= 6'd32);
   endfunction

   // Search starts one past the last grant, so the last winner has lowest
   // priority next time round.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign widx     = int'(win);
   assign w_mode   = req_mode[widx*2 +: 2];
   assign w_wr     = req_wr_width[widx*6 +: 6];
   assign w_rd     = req_rd_width[widx*6 +: 6];
   assign win_oh   = NREQ'(1) << win;
   assign grant_oh = NREQ'(1) << grant_id;

   // Only the width(s) the mode actually uses are checked.
   always_comb begin
      cfg_err = 1'b1;
      unique case (w_mode)
         2'b00:   cfg_err = !w_ok(w_rd);
         2'b01:   cfg_err = !w_ok(w_wr);
         2'b10:   cfg_err = !(w_ok(w_wr) && w_ok(w_rd));
         default: cfg_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      done_hit = 1'b0;
      to_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               accept   = 1'b1;
               state_nx = cfg_err ? GAP : RUN;
            end
         end
         RUN: begin
            if (spi_done) begin
               done_hit = 1'b1;
               state_nx = GAP;
            end
`ifdef SPI_ARB_TIMEOUT_EN
            else if (to_cnt == TW'(TIMEOUT - 1)) begin
               to_hit   = 1'b1;
               state_nx = GAP;
            end
`endif
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign req_ready = (accept && !rst) ? win_oh : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         last         <= IW'(NREQ - 1);
         grant_id     <= '0;
         spi_en       <= 1'b0;
         spi_cpol     <= 1'b0;
         spi_cpha     <= 1'b0;
         spi_w_r_mode <= '0;
         spi_wr_width <= '0;
         spi_rd_width <= '0;
         spi_wr_data  <= '0;
         rsp_valid    <= '0;
         rsp_rd_data  <= '0;
         rsp_err      <= 1'b0;
         gap_cnt      <= '0;
      end else begin
         rsp_valid <= '0;
         if (accept) begin
            last         <= win;
            grant_id     <= win;
            spi_cpol     <= req_cpol[win];
            spi_cpha     <= req_cpha[win];
            spi_w_r_mode <= w_mode;
            spi_wr_width <= w_wr;
            spi_rd_width <= w_rd;
            spi_wr_data  <= req_wr_data[widx*DW +: DW];
            if (cfg_err) begin
               rsp_valid   <= win_oh;
               rsp_err     <= 1'b1;
               rsp_rd_data <= '0;
            end else begin
               spi_en <= 1'b1;
            end
         end
         if (done_hit) begin
            spi_en      <= 1'b0;
            rsp_valid   <= grant_oh;
            rsp_err     <= 1'b0;
            rsp_rd_data <= spi_rd_data;
         end
         if (to_hit) begin
            spi_en      <= 1'b0;
            rsp_valid   <= grant_oh;
            rsp_err     <= 1'b1;
            rsp_rd_data <= '0;
         end
         if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
         else              gap_cnt <= '0;
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst || state != RUN) to_cnt <= '0;
      else                     to_cnt <= to_cnt + TW'(1);
   end
`endif

endmodule
